// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Parametrised pipeline boundary register placed between IF/ID/EX/MEM/WB.
// Carries pc, instruction word, decoded instruction code and a generic
// payload behind a valid/ready handshake. A two-entry skid buffer (main +
// skid) absorbs one extra entry after back-pressure appears, so in_ready is
// derived from registered state only and never combinationally from
// out_ready. A flush kills both held entries and leaves a nop bubble on the
// outputs. A saturating counter records cycles spent stalled downstream.
//
// Ports
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous, active-high
//   flush        in   discard held entries, insert bubble (same edge)
//   in_valid     in   upstream entry valid
//   in_ready     out  stage can accept (= skid not occupied)
//   pc_in        in   [31:0]            upstream pc
//   instr_in     in   [31:0]            upstream instruction word
//   code_in      in   [CODE_W-1:0]      upstream decoded code
//   payload_in   in   [PAYLOAD_W-1:0]   upstream payload
//   out_valid    out  main entry valid
//   out_ready    in   downstream accepts
//   pc_out       out  [31:0]            main entry pc
//   instr_out    out  [31:0]            main entry instruction
//   code_out     out  [CODE_W-1:0]      main entry code
//   payload_out  out  [PAYLOAD_W-1:0]   main entry payload
//   stall_cnt    out  [CNT_W-1:0]       out_valid & !out_ready cycles, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                PAYLOAD_W = 64,
    parameter int                CODE_W    = 6,
    parameter logic [CODE_W-1:0] NOP_CODE  = '0,
    parameter logic [31:0]       RESET_PC  = 32'h0000_3000,
    parameter int                CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          pc_in,
    input  logic [31:0]          instr_in,
    input  logic [CODE_W-1:0]    code_in,
    input  logic [PAYLOAD_W-1:0] payload_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          pc_out,
    output logic [31:0]          instr_out,
    output logic [CODE_W-1:0]    code_out,
    output logic [PAYLOAD_W-1:0] payload_out,
    output logic [CNT_W-1:0]     stall_cnt
);

    // One pipeline entry as carried across the boundary.
    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic [CODE_W-1:0]    code;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    // Occupancy: EMPTY = nothing held, ONE = main only, FULL = main + skid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    // Non-valid registers always hold this, so downstream decode sees a nop
    // whenever out_valid is low without needing to gate on it.
    localparam entry_t BUBBLE = '{
        pc:      RESET_PC,
        instr:   32'h0,
        code:    NOP_CODE,
        payload: '0
    };

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    entry_t           r_main;
    entry_t           r_skid;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state_nxt;
    entry_t           w_main_nxt;
    entry_t           w_skid_nxt;
    entry_t           w_in_entry;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_stall;

    assign w_in_entry = '{
        pc:      pc_in,
        instr:   instr_in,
        code:    code_in,
        payload: payload_in
    };

    // Both handshake signals come straight from the state register, which is
    // what keeps in_ready free of any combinational path from out_ready.
    assign w_in_ready  = (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = in_valid  & w_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;
    assign w_stall     = w_out_valid & ~out_ready;

    // Next-state / datapath selection. Reset is applied in the register
    // process; flush overrides the handshake here.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        if (flush) begin
            // A concurrent in_fire is dropped: upstream kills it with the
            // same flush.
            w_state_nxt = S_EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = w_in_entry;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = w_in_entry;
                    end else if (w_in_fire) begin
                        // Downstream stalled this cycle: park the new entry
                        // behind main; in_ready drops next cycle.
                        w_skid_nxt  = w_in_entry;
                        w_state_nxt = S_FULL;
                    end else if (w_out_fire) begin
                        w_main_nxt  = BUBBLE;
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                        w_state_nxt = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_main      <= BUBBLE;
            r_skid      <= BUBBLE;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
            // Performance counter survives flush; only reset clears it.
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign pc_out      = r_main.pc;
    assign instr_out   = r_main.instr;
    assign code_out    = r_main.code;
    assign payload_out = r_main.payload;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed scenarios followed by a randomized run. The reference is a
// two-deep FIFO queue of entries: outputs are the queue head (or the bubble
// when empty), in_ready is "fewer than two held", and a separate integer
// models the saturating stall counter.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          PW    = 64;
    localparam int          CW    = 6;
    localparam int          CNT_W = 4;
    localparam logic [31:0] RPC   = 32'h0000_3000;
    localparam logic [CW-1:0] NOPC = '0;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   pc_in, instr_in, pc_out, instr_out;
    logic [CW-1:0] code_in, code_out;
    logic [PW-1:0] payload_in, payload_out;
    logic [CNT_W-1:0] stall_cnt;

    pipe_stage_reg #(
        .PAYLOAD_W(PW), .CODE_W(CW), .NOP_CODE(NOPC), .RESET_PC(RPC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr_in(instr_in), .code_in(code_in), .payload_in(payload_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .instr_out(instr_out), .code_out(code_out),
        .payload_out(payload_out), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   instr;
        logic [CW-1:0] code;
        logic [PW-1:0] pay;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ent_t e;
        if (q.size() > 0) e = q[0];
        else e = '{pc: RPC, instr: 32'h0, code: NOPC, pay: '0};
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("pc_out",    64'(pc_out),    64'(e.pc));
        chk("instr_out", 64'(instr_out), 64'(e.instr));
        chk("code_out",  64'(code_out),  64'(e.code));
        chk("payload",   payload_out,    e.pay);
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then
    // compare on the falling edge.
    task automatic step(input logic rv, input logic fv, input logic iv,
                        input logic [31:0] pc, input logic orv);
        bit ofire, ifire;
        ent_t e;
        reset      = rv;
        flush      = fv;
        in_valid   = iv;
        out_ready  = orv;
        pc_in      = pc;
        instr_in   = $urandom;
        code_in    = CW'($urandom);
        payload_in = {$urandom, $urandom};
        e = '{pc: pc_in, instr: instr_in, code: code_in, pay: payload_in};
        @(posedge clk);
        if (rv) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (q.size() > 0 && !orv && m_cnt < CMAX) m_cnt++;
            if (fv) begin
                q.delete();
            end else begin
                ofire = (q.size() > 0) && orv;
                ifire = iv && (q.size() < 2);
                if (ofire) void'(q.pop_front());
                if (ifire) q.push_back(e);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        m_cnt = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc_in = '0; instr_in = '0; code_in = '0; payload_in = '0;
        @(negedge clk);

        // Reset held two cycles with in_valid asserted: nothing accepted.
        step(1, 0, 1, 32'h1111_0000, 0);
        step(1, 0, 1, 32'h1111_0004, 0);
        chk("rst_pc",    64'(pc_out),    64'(RPC));
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready),  64'd1);

        // Streaming at full rate.
        step(0, 0, 1, 32'h3000, 1);
        chk("stream0", 64'(pc_out), 64'h3000);
        step(0, 0, 1, 32'h3004, 1);
        chk("stream1", 64'(pc_out), 64'h3004);
        step(0, 0, 1, 32'h3008, 1);
        chk("stream2", 64'(pc_out), 64'h3008);
        step(0, 0, 0, 32'h0, 1);

        // Back-pressure: one extra entry absorbed, third held upstream.
        step(0, 0, 1, 32'h3000, 0);
        step(0, 0, 1, 32'h3004, 0);
        chk("bp_full_rdy", 64'(in_ready), 64'd0);
        step(0, 0, 1, 32'h3008, 0);
        chk("bp_hold_pc", 64'(pc_out), 64'h3000);
        step(0, 0, 1, 32'h3008, 1);
        chk("bp_drain1", 64'(pc_out), 64'h3004);
        step(0, 0, 1, 32'h3008, 1);
        chk("bp_drain2", 64'(pc_out), 64'h3008);
        step(0, 0, 0, 32'h0, 1);

        // Flush while FULL with a concurrent input.
        step(0, 0, 1, 32'h5000, 0);
        step(0, 0, 1, 32'h5004, 0);
        step(0, 1, 1, 32'h5008, 0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_code",  64'(code_out),  64'(NOPC));
        chk("fl_ready", 64'(in_ready),  64'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);

        // Stall counter saturation, flush keeps it, reset clears it.
        step(1, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h6000, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 0);
        chk("cnt_sat", 64'(stall_cnt), 64'(CMAX));
        step(0, 1, 0, 32'h0, 0);
        chk("cnt_flush", 64'(stall_cnt), 64'(CMAX));
        step(1, 0, 0, 32'h0, 0);
        chk("cnt_reset", 64'(stall_cnt), 64'd0);

        // Drain a single entry to empty.
        step(0, 0, 1, 32'h3010, 1);
        chk("drain_pc", 64'(pc_out), 64'h3010);
        step(0, 0, 0, 32'h0, 1);
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_pc0",   64'(pc_out),    64'(RPC));

        // Randomized mix of traffic, stalls, flushes and occasional reset.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 70),
                 $urandom,
                 ($urandom_range(0, 99) < 55));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline boundary register that replaces the fixed-width, always-advancing stage registers between IF/ID/EX/MEM/WB. It carries pc, instruction word, decoded instruction code and a generic payload. It adds a valid/ready handshake with a two-entry skid buffer for back-pressure, a flush input that inserts a nop bubble, and a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- PAYLOAD_W, 64, width of generic payload (e.g. alu_result + mem_read_data)
- CODE_W, 6, width of decoded instruction code
- NOP_CODE, 0, instruction code value driven for bubbles
- RESET_PC, 32'h0000_3000, pc value driven for bubbles
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- flush  in  1  discard all held entries, insert bubble
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept (registered-derived, = !skid_valid)
- pc_in  in  32  upstream pc
- instr_in  in  32  upstream instruction word
- code_in  in  CODE_W  upstream decoded instruction code
- payload_in  in  PAYLOAD_W  upstream payload
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- pc_out  out  32  main entry pc
- instr_out  out  32  main entry instruction
- code_out  out  CODE_W  main entry code
- payload_out  out  PAYLOAD_W  main entry payload
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Storage: main register (drives outputs) + skid register, each with valid bit. State = EMPTY (neither valid), ONE (main only), FULL (both).
- Bubble = {pc=RESET_PC, instr=0, code=NOP_CODE, payload=0}.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Transitions (no reset/flush):
  - EMPTY: in_fire -> main<=in, ONE; else hold.
  - ONE: in_fire & out_fire -> main<=in, ONE. in_fire only -> skid<=in, FULL. out_fire only -> main<=bubble, EMPTY. Neither -> hold.
  - FULL: in_ready=0 so no in_fire. out_fire -> main<=skid, skid<=bubble, ONE. Else hold.
- Priority: reset > flush > handshake. On flush, main and skid <= bubble, both valids cleared, state EMPTY. A concurrent in_fire is discarded. Upstream sees in_ready as driven and must treat the entry as killed by its own flush.
- Payload fields of a non-valid register always equal bubble. The downstream decoder sees NOP_CODE whenever out_valid=0.
- stall_cnt increments when out_valid & !out_ready and is not at all-ones. It holds at all-ones. It is cleared only by reset; flush does not clear it.
- Order preserved: entries leave in acceptance order, none duplicated or dropped except by flush.

## Timing
- Reset values: out_valid=0, in_ready=1, pc_out=RESET_PC, instr_out=0, code_out=NOP_CODE, payload_out=0, stall_cnt=0. While reset is high, in_ready reads 1 but in_fire is ignored.
- Latency: entry accepted at edge N is on outputs after edge N (visible cycle N+1), out_valid=1.
- Throughput: 1 entry/cycle while out_ready=1; in_ready stays 1.
- Back-pressure: in_ready drops the cycle after the skid fills. Exactly one extra entry is absorbed after out_ready falls. in_ready is not combinationally dependent on out_ready.
- in_ready returns to 1 the cycle after the FULL->ONE drain.
- Flush takes effect at the same edge. Outputs show bubble and in_ready=1 the next cycle.
- Reset mid-operation is identical to flush plus stall_cnt clear.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> outputs pc=32'h0000_3000, instr=0, code=0, out_valid=0, stall_cnt=0, no entry accepted.
- Streaming: out_ready=1, feed pc 0x3000,0x3004,0x3008 on consecutive cycles -> same pcs on outputs one cycle later each, in_ready constantly 1.
- Back-pressure: in ONE with pc 0x3000, drop out_ready, present 0x3004 then 0x3008 -> 0x3004 captured in skid, in_ready=0, 0x3008 held upstream. Raise out_ready -> outputs 0x3000,0x3004,0x3008 in order, none lost.
- Flush in FULL with concurrent in_valid -> next cycle out_valid=0, code=NOP_CODE, in_ready=1, neither old entry nor the concurrent input ever appears.
- Stall counter: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays. Flush -> still 15. Reset -> 0.
- Drain to empty: single entry pc 0x3010 consumed with no new input -> following cycle out_valid=0, outputs return to bubble values.
